// File: rtl/conv_result_writer.sv
// Channel-packed feature-map writer: turns the serial conv2 result stream
// (filter-major, raster within filter) into BRAM writes where each word holds
// PACK channel lanes of one pixel.
module conv_result_writer #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned PACK     = 6,
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned HEIGHT   = 10,
  parameter int unsigned FILTERS  = 16,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [BITWIDTH-1:0]      in_data,
  output logic                     in_ready,
  output logic [PACK-1:0]          wea,
  output logic [ADDR_W-1:0]        addra,
  output logic [PACK*BITWIDTH-1:0] dina,
  output logic                     ena,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned NPix  = WIDTH * HEIGHT;
  localparam int unsigned PixW  = (NPix > 1) ? $clog2(NPix) : 1;
  localparam int unsigned FiltW = $clog2(FILTERS + 1);
  localparam int unsigned LaneW = (PACK > 1) ? $clog2(PACK) : 1;

  localparam logic [PixW-1:0]   PixLast     = PixW'(NPix - 1);
  localparam logic [FiltW-1:0]  FiltLast    = FiltW'(FILTERS - 1);
  localparam logic [LaneW-1:0]  LaneLast    = LaneW'(PACK - 1);
  localparam logic [ADDR_W-1:0] GroupStride = ADDR_W'(NPix);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                    state_q, state_d;
  logic [PixW-1:0]           pixel_q, pixel_d;
  logic [FiltW-1:0]          filter_q, filter_d;
  logic [LaneW-1:0]          lane_q, lane_d;
  // base_q is group*WIDTH*HEIGHT, advanced by addition instead of multiplied
  logic [ADDR_W-1:0]         base_q, base_d;
  logic [PACK-1:0]           wea_q, wea_d;
  logic [ADDR_W-1:0]         addra_q, addra_d;
  logic [PACK*BITWIDTH-1:0]  dina_q, dina_d;
  logic                      ena_q, ena_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      last_beat;

  assign last_beat = (filter_q == FiltLast) && (pixel_q == PixLast);

  // Next-state: FSM, counter advance and the registered BRAM write port
  always_comb begin
    state_d  = state_q;
    pixel_d  = pixel_q;
    filter_d = filter_q;
    lane_d   = lane_q;
    base_d   = base_q;
    wea_d    = '0;
    ena_d    = 1'b0;
    addra_d  = addra_q;
    dina_d   = dina_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          pixel_d  = '0;
          filter_d = '0;
          lane_d   = '0;
          base_d   = '0;
          busy_d   = 1'b1;
        end
      end
      StRun: begin
        if (in_valid) begin
          wea_d   = PACK'(1) << lane_q;
          ena_d   = 1'b1;
          addra_d = base_q + ADDR_W'(pixel_q);
          dina_d  = '0;
          dina_d[lane_q*BITWIDTH +: BITWIDTH] = in_data;

          if (pixel_q == PixLast) begin
            pixel_d  = '0;
            filter_d = filter_q + 1'b1;
            if (lane_q == LaneLast) begin
              lane_d = '0;
              base_d = base_q + GroupStride;
            end else begin
              lane_d = lane_q + 1'b1;
            end
          end else begin
            pixel_d = pixel_q + 1'b1;
          end

          if (last_beat) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // Final write is on the port this cycle; report completion next cycle
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pixel_q  <= '0;
      filter_q <= '0;
      lane_q   <= '0;
      base_q   <= '0;
      wea_q    <= '0;
      addra_q  <= '0;
      dina_q   <= '0;
      ena_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pixel_q  <= pixel_d;
      filter_q <= filter_d;
      lane_q   <= lane_d;
      base_q   <= base_d;
      wea_q    <= wea_d;
      addra_q  <= addra_d;
      dina_q   <= dina_d;
      ena_q    <= ena_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign wea      = wea_q;
  assign addra    = addra_q;
  assign dina     = dina_q;
  assign ena      = ena_q;
  assign busy     = busy_q;
  assign in_ready = busy_q;
  assign done     = done_q;

endmodule
